// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b memory types and write buffer defaults
package lc3b_types;

   typedef logic [11:0]  lc3b_wb_adr;
   typedef logic [127:0] lc3b_line;

   typedef enum logic {
      wb_idle,
      wb_write
   } lc3b_wbuf_state;

   localparam int WBUF_DEPTH = 4;

endpackage

// File: rtl/lc3b_wbuf_match.sv
// rtl/lc3b_wbuf_match.sv - per-entry address comparator with youngest-match select
module lc3b_wbuf_match #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 12
) (
   input  logic [DEPTH*ADDR_W-1:0]  entry_addr,
   input  logic [DEPTH-1:0]         entry_valid,
   input  logic [DEPTH-1:0]         inflight_mask,
   input  logic [ADDR_W-1:0]        cmp_addr,
   output logic [DEPTH-1:0]         match,
   output logic [$clog2(DEPTH)-1:0] match_idx
);

   localparam int IDX_W = $clog2(DEPTH);

   // At most one queued copy plus the in-flight head can match; the queued copy is newer.
   always_comb begin
      match     = '0;
      match_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match[i] = entry_valid[i] && (entry_addr[i*ADDR_W +: ADDR_W] == cmp_addr);
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (match[i] && inflight_mask[i]) match_idx = IDX_W'(i);
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (match[i] && !inflight_mask[i]) match_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/lc3b_write_buffer.sv
// rtl/lc3b_write_buffer.sv - coalescing eviction write buffer between L2 and memory
module lc3b_write_buffer
   import lc3b_types::*;
#(
   parameter int DEPTH  = WBUF_DEPTH,
   parameter int ADDR_W = $bits(lc3b_wb_adr),
   parameter int LINE_W = $bits(lc3b_line)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     evict_valid,
   input  logic [ADDR_W-1:0]        evict_addr,
   input  logic [LINE_W-1:0]        evict_data,
   output logic                     evict_ready,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic                     rd_hit,
   output logic [LINE_W-1:0]        rd_data,
   input  logic                     drain_en,
   output logic                     pmem_write,
   output logic [ADDR_W-1:0]        pmem_address,
   output logic [LINE_W-1:0]        pmem_wdata,
   input  logic                     pmem_resp,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   lc3b_wbuf_state state_q, state_d;

   logic [DEPTH*ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0]       data_q [DEPTH];
   logic [LINE_W-1:0]       data_d [DEPTH];
   logic [DEPTH-1:0]        valid_q, valid_d;
   logic [PTR_W-1:0]        head_q, head_d;
   logic [PTR_W-1:0]        tail_q, tail_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [ADDR_W-1:0]       pmem_address_q, pmem_address_d;
   logic [LINE_W-1:0]       pmem_wdata_q, pmem_wdata_d;

   logic             start, pop, accept, coalesce, alloc;
   logic [DEPTH-1:0] inflight;
   logic [DEPTH-1:0] c_match, f_match;
   logic [PTR_W-1:0] c_idx, f_idx;

   assign empty       = (count_q == '0);
   assign full        = (count_q == CNT_W'(DEPTH));
   assign count       = count_q;
   assign evict_ready = !full;
   assign start       = (state_q == wb_idle) && !empty && drain_en;

   // The head counts as in flight on the launch edge too, so a same-edge re-evict
   // allocates instead of overwriting data that is being latched.
   assign inflight = (pmem_write || start) ? (DEPTH'(1) << head_q) : '0;
   assign accept   = evict_valid && evict_ready;
   assign coalesce = accept && |(c_match & ~inflight);
   assign alloc    = accept && !coalesce;

   lc3b_wbuf_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_coal_match (
      .entry_addr    (addr_q),
      .entry_valid   (valid_q),
      .inflight_mask (inflight),
      .cmp_addr      (evict_addr),
      .match         (c_match),
      .match_idx     (c_idx)
   );

   lc3b_wbuf_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fwd_match (
      .entry_addr    (addr_q),
      .entry_valid   (valid_q),
      .inflight_mask (inflight),
      .cmp_addr      (rd_addr),
      .match         (f_match),
      .match_idx     (f_idx)
   );

   assign rd_hit  = |f_match;
   assign rd_data = rd_hit ? data_q[f_idx] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= wb_idle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         wb_idle:  if (start)     state_d = wb_write;
         wb_write: if (pmem_resp) state_d = wb_idle;
         default:                 state_d = wb_idle;
      endcase
   end

   always_comb begin
      pmem_write   = (state_q == wb_write);
      pop          = pmem_write && pmem_resp;
      pmem_address = pmem_address_q;
      pmem_wdata   = pmem_wdata_q;
   end

   always_comb begin
      addr_d         = addr_q;
      data_d         = data_q;
      valid_d        = valid_q;
      head_d         = head_q;
      tail_d         = tail_q;
      pmem_address_d = pmem_address_q;
      pmem_wdata_d   = pmem_wdata_q;
      if (start) begin
         pmem_address_d = addr_q[int'(head_q)*ADDR_W +: ADDR_W];
         pmem_wdata_d   = data_q[head_q];
      end
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end
      if (coalesce) begin
         data_d[c_idx] = evict_data;
      end else if (alloc) begin
         addr_d[int'(tail_q)*ADDR_W +: ADDR_W] = evict_addr;
         data_d[tail_q]  = evict_data;
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + 1'b1;
      end
      count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q         <= '0;
         valid_q        <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
         for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
         addr_q         <= addr_d;
         valid_q        <= valid_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         pmem_address_q <= pmem_address_d;
         pmem_wdata_q   <= pmem_wdata_d;
         for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
      end
   end

endmodule

// File: tb/tb_lc3b_write_buffer.sv
// tb/tb_lc3b_write_buffer.sv - directed self-checking bench for lc3b_write_buffer
module tb_lc3b_write_buffer;

   localparam int ADDR_W = 12;
   localparam int LINE_W = 128;

   logic              clk, rst;
   logic              evict_valid, evict_ready;
   logic [ADDR_W-1:0] evict_addr, rd_addr, pmem_address;
   logic [LINE_W-1:0] evict_data, rd_data, pmem_wdata;
   logic              rd_hit, drain_en, pmem_write, pmem_resp, empty, full;
   logic [2:0]        count;

   int checks   = 0;
   int failures = 0;

   localparam logic [LINE_W-1:0] DATA_A    = {4{32'hAAAA_0001}};
   localparam logic [LINE_W-1:0] DATA_B    = {4{32'hBBBB_0002}};
   localparam logic [LINE_W-1:0] DATA_C    = {4{32'hCCCC_0003}};
   localparam logic [LINE_W-1:0] DATA_DEAD = 128'h0000_0000_0000_0000_0000_0000_0000_DEAD;

   lc3b_write_buffer dut (
      .clk          (clk),
      .rst          (rst),
      .evict_valid  (evict_valid),
      .evict_addr   (evict_addr),
      .evict_data   (evict_data),
      .evict_ready  (evict_ready),
      .rd_addr      (rd_addr),
      .rd_hit       (rd_hit),
      .rd_data      (rd_data),
      .drain_en     (drain_en),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_resp    (pmem_resp),
      .empty        (empty),
      .full         (full),
      .count        (count)
   );

   always #5 clk = ~clk;

   function automatic logic [LINE_W-1:0] mkdata(input logic [ADDR_W-1:0] a);
      return {32'h5A5A_5A5A, 84'h0, a};
   endfunction

   task automatic evict(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
      evict_valid = 1'b1;
      evict_addr  = a;
      evict_data  = d;
      @(posedge clk); #1;
      evict_valid = 1'b0;
   endtask

   task automatic respond();
      pmem_resp = 1'b1;
      @(posedge clk); #1;
      pmem_resp = 1'b0;
   endtask

   task automatic wait_write();
      int n = 0;
      while (!pmem_write && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!pmem_write) begin
         failures++;
         $display("FAIL wait_write got=timeout exp=pmem_write");
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({pmem_write, evict_ready, empty, full, rd_hit, count} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=%b", {pmem_write, evict_ready, empty, full, rd_hit, count}, 8'b01100000);
      end
      checks++;
      if (pmem_address !== 12'h000 || pmem_wdata !== '0) begin
         failures++;
         $display("FAIL reset_pmem got=%h/%h exp=0/0", pmem_address, pmem_wdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      drain_en = 1'b1;
      evict(12'h0A5, DATA_DEAD);
      checks++;
      if (pmem_write !== 1'b0 || count !== 3'd1) begin
         failures++;
         $display("FAIL single_accept got=%b/%0d exp=0/1", pmem_write, count);
      end
      @(posedge clk); #1;
      checks++;
      if (pmem_write !== 1'b1 || pmem_address !== 12'h0A5 || pmem_wdata !== DATA_DEAD) begin
         failures++;
         $display("FAIL single_start got=%b/%h/%h exp=1/0a5/%h", pmem_write, pmem_address, pmem_wdata, DATA_DEAD);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (pmem_write !== 1'b1 || pmem_address !== 12'h0A5 || pmem_wdata !== DATA_DEAD) begin
            failures++;
            $display("FAIL single_hold got=%b/%h exp=1/0a5", pmem_write, pmem_address);
         end
      end
      respond();
      checks++;
      if (pmem_write !== 1'b0 || empty !== 1'b1 || count !== 3'd0) begin
         failures++;
         $display("FAIL single_done got=%b/%b/%0d exp=0/1/0", pmem_write, empty, count);
      end
   endtask

   task automatic test_fill_stall();
      drain_en = 1'b0;
      for (int k = 1; k <= 4; k++) evict(ADDR_W'(k), mkdata(ADDR_W'(k)));
      checks++;
      if (full !== 1'b1 || evict_ready !== 1'b0 || count !== 3'd4) begin
         failures++;
         $display("FAIL fill_full got=%b/%b/%0d exp=1/0/4", full, evict_ready, count);
      end
      evict(12'h005, mkdata(12'h005));
      rd_addr = 12'h005;
      #1;
      checks++;
      if (count !== 3'd4 || rd_hit !== 1'b0) begin
         failures++;
         $display("FAIL fill_reject got=%0d/%b exp=4/0", count, rd_hit);
      end
      drain_en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         wait_write();
         checks++;
         if (pmem_address !== ADDR_W'(k) || pmem_wdata !== mkdata(ADDR_W'(k))) begin
            failures++;
            $display("FAIL fill_order got=%h exp=%h", pmem_address, ADDR_W'(k));
         end
         respond();
      end
      checks++;
      if (empty !== 1'b1) begin
         failures++;
         $display("FAIL fill_empty got=%b exp=1", empty);
      end
   endtask

   task automatic test_coalesce();
      logic seen;
      drain_en = 1'b0;
      evict(12'h010, DATA_A);
      evict(12'h010, DATA_B);
      rd_addr = 12'h010;
      #1;
      checks++;
      if (count !== 3'd1 || rd_hit !== 1'b1 || rd_data !== DATA_B) begin
         failures++;
         $display("FAIL coalesce_fwd got=%0d/%b/%h exp=1/1/%h", count, rd_hit, rd_data, DATA_B);
      end
      drain_en = 1'b1;
      wait_write();
      checks++;
      if (pmem_address !== 12'h010 || pmem_wdata !== DATA_B) begin
         failures++;
         $display("FAIL coalesce_write got=%h/%h exp=010/%h", pmem_address, pmem_wdata, DATA_B);
      end
      respond();
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         seen |= pmem_write;
      end
      checks++;
      if (seen !== 1'b0 || empty !== 1'b1) begin
         failures++;
         $display("FAIL coalesce_single got=%b/%b exp=0/1", seen, empty);
      end
   endtask

   task automatic test_reevict_inflight();
      drain_en = 1'b1;
      evict(12'h020, DATA_A);
      wait_write();
      evict(12'h020, DATA_C);
      rd_addr = 12'h020;
      #1;
      checks++;
      if (count !== 3'd2 || rd_hit !== 1'b1 || rd_data !== DATA_C) begin
         failures++;
         $display("FAIL reevict_fwd got=%0d/%b/%h exp=2/1/%h", count, rd_hit, rd_data, DATA_C);
      end
      checks++;
      if (pmem_address !== 12'h020 || pmem_wdata !== DATA_A) begin
         failures++;
         $display("FAIL reevict_first got=%h/%h exp=020/%h", pmem_address, pmem_wdata, DATA_A);
      end
      respond();
      wait_write();
      checks++;
      if (pmem_address !== 12'h020 || pmem_wdata !== DATA_C) begin
         failures++;
         $display("FAIL reevict_second got=%h/%h exp=020/%h", pmem_address, pmem_wdata, DATA_C);
      end
      respond();
   endtask

   task automatic test_back_to_back();
      logic [ADDR_W-1:0] a;
      drain_en = 1'b0;
      evict(12'h100, mkdata(12'h100));
      evict(12'h101, mkdata(12'h101));
      drain_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = 12'h100 + ADDR_W'(i);
         wait_write();
         checks++;
         if (pmem_address !== a || pmem_wdata !== mkdata(a)) begin
            failures++;
            $display("FAIL b2b_order got=%h exp=%h", pmem_address, a);
         end
         pmem_resp   = 1'b1;
         evict_valid = 1'b1;
         evict_addr  = a + 12'h002;
         evict_data  = mkdata(a + 12'h002);
         @(posedge clk); #1;
         pmem_resp   = 1'b0;
         evict_valid = 1'b0;
         checks++;
         if (count !== 3'd2) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=2", count);
         end
      end
      for (int i = 8; i < 10; i++) begin
         a = 12'h100 + ADDR_W'(i);
         wait_write();
         checks++;
         if (pmem_address !== a || pmem_wdata !== mkdata(a)) begin
            failures++;
            $display("FAIL b2b_tail got=%h exp=%h", pmem_address, a);
         end
         respond();
      end
      checks++;
      if (empty !== 1'b1) begin
         failures++;
         $display("FAIL b2b_empty got=%b exp=1", empty);
      end
   endtask

   task automatic test_async_reset();
      drain_en = 1'b0;
      evict(12'h030, DATA_A);
      evict(12'h031, DATA_B);
      drain_en = 1'b1;
      wait_write();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (pmem_write !== 1'b0 || empty !== 1'b1 || count !== 3'd0) begin
         failures++;
         $display("FAIL areset_drop got=%b/%b/%0d exp=0/1/0", pmem_write, empty, count);
      end
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      rd_addr = 12'h030;
      #1;
      checks++;
      if (rd_hit !== 1'b0 || evict_ready !== 1'b1 || pmem_write !== 1'b0) begin
         failures++;
         $display("FAIL areset_030 got=%b/%b/%b exp=0/1/0", rd_hit, evict_ready, pmem_write);
      end
      rd_addr = 12'h031;
      #1;
      checks++;
      if (rd_hit !== 1'b0 || pmem_address !== 12'h000) begin
         failures++;
         $display("FAIL areset_031 got=%b/%h exp=0/000", rd_hit, pmem_address);
      end
   endtask

   initial begin
      clk         = 1'b0;
      rst         = 1'b1;
      evict_valid = 1'b0;
      evict_addr  = '0;
      evict_data  = '0;
      rd_addr     = '0;
      drain_en    = 1'b0;
      pmem_resp   = 1'b0;
      test_reset();
      test_single();
      test_fill_stall();
      test_coalesce();
      test_reevict_inflight();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
